// File: rtl/ram_gen_pkg.sv
// Shared types and helpers for the generic dual-port RAM.
package ram_gen_pkg;

  typedef enum logic {CLEAR, READY} ram_state_t;

  localparam int MIN_LATENCY = 1;
  localparam int MAX_DATA_W  = 1024;
  localparam int MAX_BE_W    = MAX_DATA_W / 8;

  // Replace each enabled byte of old_word with the matching byte of wdata.
  function automatic logic [MAX_DATA_W-1:0] be_merge(input logic [MAX_DATA_W-1:0] old_word,
                                                     input logic [MAX_DATA_W-1:0] wdata,
                                                     input logic [MAX_BE_W-1:0]   be);
    logic [MAX_DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < MAX_BE_W; i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_dual_port_rdpipe.sv
// Read-latency pipeline for one RAM port: data + valid shift register that stalls on clken.
module ram_dual_port_rdpipe
  import ram_gen_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clken,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] q,
  output logic              q_valid
);

  localparam int STAGES = (LATENCY < MIN_LATENCY) ? MIN_LATENCY : LATENCY;

  logic [DATA_W-1:0] d [STAGES];
  logic [STAGES-1:0] v;

  // Data only advances alongside a valid token, so q keeps the last read word.
  always_ff @(posedge clk) begin
    if (reset) begin
      v <= '0;
      for (int i = 0; i < STAGES; i++) d[i] <= '0;
    end else if (clken) begin
      v[0] <= in_valid;
      if (in_valid) d[0] <= in_data;
      for (int i = 1; i < STAGES; i++) begin
        v[i] <= v[i-1];
        if (v[i-1]) d[i] <= d[i-1];
      end
    end
  end

  assign q       = d[STAGES-1];
  assign q_valid = v[STAGES-1];

endmodule

// File: rtl/ram_dual_port_gen.sv
// Inferred true dual-port RAM with byte enables, valid-tagged reads and post-reset clear sweep.
// Define RAM_DUAL_PORT_FWD_EN to forward the other port's same-cycle write to a colliding read.
module ram_dual_port_gen
  import ram_gen_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 8,
  parameter int DEPTH          = 2**ADDR_W,
  parameter int LATENCY        = 1,
  parameter int BE_W           = DATA_W / 8,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clken,
  input  logic              rden_a,
  input  logic              wren_a,
  input  logic [ADDR_W-1:0] address_a,
  input  logic [BE_W-1:0]   byteena_a,
  input  logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] q_a,
  output logic              q_valid_a,
  input  logic              rden_b,
  input  logic              wren_b,
  input  logic [ADDR_W-1:0] address_b,
  input  logic [BE_W-1:0]   byteena_b,
  input  logic [DATA_W-1:0] data_b,
  output logic [DATA_W-1:0] q_b,
  output logic              q_valid_b,
  output logic              busy,
  output logic              collision
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] o,
                                               input logic [DATA_W-1:0] w,
                                               input logic [BE_W-1:0]   be);
    return DATA_W'(be_merge(MAX_DATA_W'(o), MAX_DATA_W'(w), MAX_BE_W'(be)));
  endfunction

  ram_state_t        state;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              ready_en, in_a, in_b, wr_a, wr_b, rd_a, rd_b, same_addr;
  logic [DATA_W-1:0] old_a, old_b, st_a, st_b, rd_word_a, rd_word_b;

  assign ready_en  = (state == READY) && clken && !reset;
  assign in_a      = {1'b0, address_a} < DEPTH_L;
  assign in_b      = {1'b0, address_b} < DEPTH_L;
  assign wr_a      = ready_en && wren_a && in_a;
  assign wr_b      = ready_en && wren_b && in_b;
  assign rd_a      = ready_en && rden_a;
  assign rd_b      = ready_en && rden_b;
  assign same_addr = (address_a == address_b);
  assign old_a     = in_a ? mem[address_a] : '0;
  assign old_b     = in_b ? mem[address_b] : '0;

  // st_a is the final word at address_a: B bytes first, then A on top so A wins overlaps.
  always_comb begin
    st_b = merge(old_b, data_b, byteena_b);
    st_a = merge((wr_b && same_addr) ? st_b : old_a, data_a, byteena_a);
`ifdef RAM_DUAL_PORT_FWD_EN
    rd_word_a = wr_a ? st_a : ((wr_b && same_addr) ? st_b : old_a);
    rd_word_b = (wr_a && same_addr) ? st_a : (wr_b ? st_b : old_b);
`else
    rd_word_a = wr_a ? merge(old_a, data_a, byteena_a) : old_a;
    rd_word_b = wr_b ? st_b : old_b;
`endif
    if (!in_a) rd_word_a = '0;
    if (!in_b) rd_word_b = '0;
  end

  // A is written last so its nonblocking update wins when both ports hit one address.
  always_ff @(posedge clk) begin
    if (!reset && state == CLEAR) begin
      mem[clr_addr] <= '0;
    end else begin
      if (wr_b) mem[address_b] <= st_b;
      if (wr_a) mem[address_a] <= st_a;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      busy      <= (CLEAR_ON_RESET != 0);
      clr_addr  <= '0;
      collision <= 1'b0;
    end else begin
      collision <= wr_a && wr_b && same_addr;
      if (state == CLEAR) begin
        clr_addr <= clr_addr + ADDR_W'(1);
        if (clr_addr == LAST_ADDR) begin
          state    <= READY;
          busy     <= 1'b0;
          clr_addr <= '0;
        end
      end
    end
  end

  ram_dual_port_rdpipe #(.DATA_W(DATA_W), .LATENCY(LATENCY)) u_pipe_a (
    .clk(clk), .reset(reset), .clken(clken),
    .in_valid(rd_a), .in_data(rd_word_a), .q(q_a), .q_valid(q_valid_a)
  );

  ram_dual_port_rdpipe #(.DATA_W(DATA_W), .LATENCY(LATENCY)) u_pipe_b (
    .clk(clk), .reset(reset), .clken(clken),
    .in_valid(rd_b), .in_data(rd_word_b), .q(q_b), .q_valid(q_valid_b)
  );

endmodule

// File: tb/tb_ram_dual_port_gen.sv
// Scoreboard bench for ram_dual_port_gen: directed scenarios followed by random traffic.
module tb_ram_dual_port_gen;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 8;
  localparam int DEPTH   = 256;
  localparam int LATENCY = 3;
  localparam int BE_W    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, clken;
  logic              rden_a, wren_a, rden_b, wren_b;
  logic [ADDR_W-1:0] address_a, address_b;
  logic [BE_W-1:0]   byteena_a, byteena_b;
  logic [DATA_W-1:0] data_a, data_b, q_a, q_b;
  logic              q_valid_a, q_valid_b, busy, collision;

  ram_dual_port_gen #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LATENCY(LATENCY),
    .BE_W(BE_W), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .reset(reset), .clken(clken),
    .rden_a(rden_a), .wren_a(wren_a), .address_a(address_a), .byteena_a(byteena_a),
    .data_a(data_a), .q_a(q_a), .q_valid_a(q_valid_a),
    .rden_b(rden_b), .wren_b(wren_b), .address_b(address_b), .byteena_b(byteena_b),
    .data_b(data_b), .q_b(q_b), .q_valid_b(q_valid_b),
    .busy(busy), .collision(collision)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t        sbq [2][$];
  logic [31:0] ref_mem [DEPTH];
  int          sweep_left = 0;
  int          en_edges   = 0;
  logic        exp_busy   = 1'b1;
  logic        exp_coll   = 1'b0;
  int          checks     = 0;
  int          errors     = 0;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w,
                                        input logic [3:0] be);
    for (int i = 0; i < 4; i++) if (be[i]) o[8*i +: 8] = w[8*i +: 8];
    return o;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference model: predicts the effect of the upcoming posedge from the driven inputs.
  task automatic model();
    logic [31:0] old_a, old_b, ra, rb;
    exp_coll = 1'b0;
    if (reset) begin
      sbq[0].delete();
      sbq[1].delete();
      foreach (ref_mem[i]) ref_mem[i] = '0;
      sweep_left = DEPTH;
      exp_busy   = 1'b1;
    end else if (sweep_left > 0) begin
      sweep_left--;
      exp_busy = (sweep_left > 0);
    end else begin
      exp_busy = 1'b0;
      if (clken) begin
        old_a = ref_mem[address_a];
        old_b = ref_mem[address_b];
        if (wren_b) ref_mem[address_b] = merge(ref_mem[address_b], data_b, byteena_b);
        if (wren_a) ref_mem[address_a] = merge(ref_mem[address_a], data_a, byteena_a);
`ifdef RAM_DUAL_PORT_FWD_EN
        ra = ref_mem[address_a];
        rb = ref_mem[address_b];
`else
        ra = wren_a ? merge(old_a, data_a, byteena_a) : old_a;
        rb = wren_b ? merge(old_b, data_b, byteena_b) : old_b;
`endif
        if (rden_a) sbq[0].push_back('{due: en_edges + LATENCY, data: ra});
        if (rden_b) sbq[1].push_back('{due: en_edges + LATENCY, data: rb});
        exp_coll = wren_a && wren_b && (address_a == address_b);
      end
    end
  endtask

  task automatic step();
    model();
    @(negedge clk);
  endtask

  task automatic idle();
    reset = 1'b0; clken = 1'b1;
    rden_a = 1'b0; wren_a = 1'b0; rden_b = 1'b0; wren_b = 1'b0;
  endtask

  task automatic set_a(input logic rd, input logic wr, input logic [7:0] ad,
                       input logic [3:0] be, input logic [31:0] d);
    rden_a = rd; wren_a = wr; address_a = ad; byteena_a = be; data_a = d;
  endtask

  task automatic set_b(input logic rd, input logic wr, input logic [7:0] ad,
                       input logic [3:0] be, input logic [31:0] d);
    rden_b = rd; wren_b = wr; address_b = ad; byteena_b = be; data_b = d;
  endtask

  // Reset for two cycles, then count busy cycles; a write issued mid-sweep must be lost.
  task automatic reset_and_sweep(input int pre_cycles);
    int busy_cycles;
    idle();
    reset = 1'b1;
    step(); step();
    idle();
    for (int i = 0; i < pre_cycles; i++) step();
    if (pre_cycles > 0) begin
      reset = 1'b1;
      step();
      idle();
    end
    busy_cycles = 0;
    for (int i = 0; i < 2*DEPTH; i++) begin
      if (!busy) break;
      busy_cycles++;
      if (i == 150) set_a(1'b1, 1'b1, 8'd7, 4'hF, 32'h12345678);
      else idle();
      step();
    end
    idle();
    chk("busy_len", busy_cycles, DEPTH);
  endtask

  task automatic port_chk(input int p, input logic v, input logic [31:0] d);
    exp_t e;
    if (v) begin
      if (sbq[p].size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid_%0d: got q_valid=1 expected 0", p);
      end else begin
        e = sbq[p].pop_front();
        chk($sformatf("latency_%0d", p), en_edges, e.due);
        chk($sformatf("rdata_%0d", p), d, e.data);
      end
    end else if (sbq[p].size() > 0 && sbq[p][0].due <= en_edges) begin
      e = sbq[p].pop_front();
      chk($sformatf("missing_valid_%0d", p), v, 1'b1);
    end
  endtask

  logic        mon_ce, mon_rs;
  logic [32:0] last_a, last_b;

  always @(posedge clk) begin
    mon_ce = clken;
    mon_rs = reset;
    #1;
    if (mon_rs) begin
      chk("reset_qvalid", {q_valid_a, q_valid_b}, 2'b00);
      chk("reset_q", {q_a, q_b}, 64'd0);
    end else if (mon_ce) begin
      en_edges++;
      port_chk(0, q_valid_a, q_a);
      port_chk(1, q_valid_b, q_b);
    end else begin
      chk("hold_a", {q_valid_a, q_a}, last_a);
      chk("hold_b", {q_valid_b, q_b}, last_b);
    end
    chk("busy", busy, exp_busy);
    chk("collision", collision, exp_coll);
    last_a = {q_valid_a, q_a};
    last_b = {q_valid_b, q_b};
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    idle();
    set_a(1'b0, 1'b0, '0, '0, '0);
    set_b(1'b0, 1'b0, '0, '0, '0);

    // Reset + full sweep, then read both ends of the array.
    reset_and_sweep(0);
    set_a(1'b1, 1'b0, 8'h00, 4'h0, 32'h0);
    set_b(1'b1, 1'b0, 8'hFF, 4'h0, 32'h0);
    step();
    idle(); repeat (LATENCY + 1) step();

    // A writes, B reads the same word on the next cycle.
    set_a(1'b0, 1'b1, 8'd5, 4'hF, 32'hDEADBEEF); step();
    idle(); set_b(1'b1, 1'b0, 8'd5, 4'h0, 32'h0); step();
    idle(); repeat (LATENCY + 1) step();

    // Stall the pipe for four cycles with a read in flight.
    set_a(1'b1, 1'b0, 8'd5, 4'h0, 32'h0); step();
    idle(); step();
    clken = 1'b0; repeat (4) step();
    idle(); repeat (LATENCY + 1) step();

    // Write-write collision with partial byte overlap, then read back.
    set_a(1'b0, 1'b1, 8'd9, 4'b0011, 32'h11111111);
    set_b(1'b0, 1'b1, 8'd9, 4'b0110, 32'h22222222);
    step();
    idle(); set_a(1'b1, 1'b0, 8'd9, 4'h0, 32'h0); step();
    idle(); repeat (LATENCY + 1) step();

    // Mixed-port read during write.
    set_a(1'b0, 1'b1, 8'd3, 4'hF, 32'hAAAAAAAA); step();
    set_a(1'b0, 1'b1, 8'd3, 4'hF, 32'h55555555);
    set_b(1'b1, 1'b0, 8'd3, 4'h0, 32'h0);
    step();
    idle(); repeat (LATENCY + 1) step();

    // Reset mid-sweep, write during busy is dropped.
    reset_and_sweep(100);
    set_a(1'b1, 1'b0, 8'd7, 4'h0, 32'h0); step();
    idle(); repeat (LATENCY + 1) step();

    // Random traffic concentrated on a few addresses to provoke collisions.
    for (int i = 0; i < 800; i++) begin
      reset = 1'b0;
      clken = ($urandom_range(0, 9) != 0);
      set_a($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
            ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), $urandom);
      set_b($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
            ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), $urandom);
      step();
    end
    idle(); repeat (LATENCY + 3) step();
    chk("drain_a", sbq[0].size(), 0);
    chk("drain_b", sbq[1].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
